trs80_video_tx: RTL and testbench

//  TRS-80-style raster transmitter, the source-side twin of the vid80 capture path. Scans a byte-wide frame buffer.

---
 rtl/trs80_video_pkg.sv | 36 +++
 rtl/trs80_pixel_shifter.sv | 29 ++
 rtl/trs80_video_tx.sv | 150 +++++++++++++++
 tb/tb_trs80_video_tx.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trs80_video_pkg.sv
// trs80_video_pkg: shared mode constants, frame-buffer address layout and the
// built-in test-pattern byte generator for the TRS-80 raster transmitter.
package trs80_video_pkg;

   // Horizontal timing for 64-column and 80-column modes (dots)
   localparam int H_TOTAL_64  = 640;
   localparam int H_ACTIVE_64 = 512;
   localparam int H_TOTAL_80  = 800;
   localparam int H_ACTIVE_80 = 640;

   // Vertical timing (lines)
   localparam int V_TOTAL_60  = 264;
   localparam int V_TOTAL_50  = 312;
   localparam int V_ACTIVE_64 = 192;
   localparam int V_ACTIVE_80 = 240;

   localparam int ADDR_W = 15;

   // Frame-buffer byte address: column in the high bits, row in the low bits
   typedef struct packed {
      logic [6:0] col;
      logic [7:0] row;
   } rd_addr_t;

   // Border is fully lit; interior is a checkerboard of alternating-dot bytes
   function automatic logic [7:0] pattern_byte(input logic [6:0] col, input logic [7:0] row,
                                               input logic [6:0] last_col, input logic [7:0] last_row);
      if (col == 7'd0 || col == last_col || row == 8'd0 || row == last_row)
         return 8'hFF;
      else if (col[0] ^ row[0])
         return 8'hAA;
      else
         return 8'h55;
   endfunction

endpackage

// File: rtl/trs80_pixel_shifter.sv
// trs80_pixel_shifter: 8-bit dot serializer. Loads a byte (or zeros when the
// fetch behind it was not valid), then shifts left MSB-first, filling zeros.
module trs80_pixel_shifter (
   input  logic       dotclk,
   input  logic       reset,
   input  logic       clear,
   input  logic       load,
   input  logic       load_valid,
   input  logic [7:0] load_data,
   output logic       dot
);

   logic [7:0] shifter;

   // Load on the byte boundary, otherwise shift the next dot into the MSB
   always_ff @(posedge dotclk or posedge reset) begin
      if (reset)
         shifter <= 8'h00;
      else if (clear)
         shifter <= 8'h00;
      else if (load)
         shifter <= load_valid ? load_data : 8'h00;
      else
         shifter <= {shifter[6:0], 1'b0};
   end

   assign dot = shifter[7];

endmodule

// File: rtl/trs80_video_tx.sv
// trs80_video_tx: TRS-80-style raster transmitter. Scans a byte-wide frame
// buffer and emits hsync (active high), vsync (active low) and serial dots.
// Optional feature macro: TRS80_TX_TEST_PATTERN_EN adds a test_mode input that
// replaces frame-buffer data with a built-in border/checkerboard pattern.
module trs80_video_tx
   import trs80_video_pkg::*;
#(
   parameter int H_TOTAL      = H_TOTAL_80,
   parameter int H_ACTIVE     = H_ACTIVE_80,
   parameter int H_SYNC_START = 680,
   parameter int H_SYNC_WIDTH = 64,
   parameter int V_TOTAL      = V_TOTAL_60,
   parameter int V_ACTIVE     = V_ACTIVE_80,
   parameter int V_SYNC_START = 250,
   parameter int V_SYNC_WIDTH = 4,
   parameter int RD_LATENCY   = 2
) (
   input  logic              dotclk,
   input  logic              reset,
   input  logic              enable,
`ifdef TRS80_TX_TEST_PATTERN_EN
   input  logic              test_mode,
`endif
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              pixel_out,
   output logic              frame_start
);

   if (H_TOTAL % 8 != 0 || H_TOTAL > 1024) begin : g_bad_h_total
      $error("H_TOTAL must be a multiple of 8 and at most 1024");
   end
   if (H_ACTIVE % 8 != 0 || H_ACTIVE > 1016) begin : g_bad_h_active
      $error("H_ACTIVE must be a multiple of 8 and at most 1016");
   end
   if (RD_LATENCY < 1 || RD_LATENCY > 6) begin : g_bad_latency
      $error("RD_LATENCY must be in 1..6");
   end

   localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [8:0]  V_LAST    = 9'(V_TOTAL - 1);
   localparam logic [7:0]  COLS_ALL  = 8'(H_TOTAL / 8);
   localparam logic [7:0]  COLS_ACT  = 8'(H_ACTIVE / 8);
   localparam logic [8:0]  ROWS_ACT  = 9'(V_ACTIVE);
   localparam logic [2:0]  SLOT      = 3'(7 - RD_LATENCY);
   localparam logic [10:0] HS_BEGIN  = 11'(H_SYNC_START);
   localparam logic [10:0] HS_END    = 11'(H_SYNC_START + H_SYNC_WIDTH);
   localparam logic [9:0]  VS_BEGIN  = 10'(V_SYNC_START);
   localparam logic [9:0]  VS_END    = 10'(V_SYNC_START + V_SYNC_WIDTH);

   logic [9:0] hcnt, h_n;
   logic [8:0] vcnt, v_n;
   logic       running;
   logic       fetch_valid;
   logic [7:0] tgt_col;
   logic [8:0] tgt_row;
   logic       slot, issue, load, fetch_block;
   logic [7:0] load_data;
   rd_addr_t   addr_q;

   // Next counter position; the first enabled edge after idle lands on (0,0)
   always_comb begin
      h_n = '0;
      v_n = '0;
      if (running) begin
         if (hcnt == H_LAST) begin
            h_n = '0;
            v_n = (vcnt == V_LAST) ? 9'd0 : vcnt + 9'd1;
         end else begin
            h_n = hcnt + 10'd1;
            v_n = vcnt;
         end
      end
   end

   // Fetch target for the byte displayed in the following 8-dot group
   always_comb begin
      tgt_col = {1'b0, h_n[9:3]} + 8'd1;
      tgt_row = v_n;
      if (tgt_col == COLS_ALL) begin
         tgt_col = 8'd0;
         tgt_row = (v_n == V_LAST) ? 9'd0 : v_n + 9'd1;
      end
      slot  = (h_n[2:0] == SLOT);
      issue = slot && (tgt_col < COLS_ACT) && (tgt_row < ROWS_ACT);
   end

   // Counters, syncs, fetch strobe/address and the fetch-valid marker
   always_ff @(posedge dotclk or posedge reset) begin
      if (reset || !enable) begin
         running     <= 1'b0;
         hcnt        <= '0;
         vcnt        <= '0;
         hsync_out   <= 1'b0;
         vsync_out   <= 1'b1;
         frame_start <= 1'b0;
         rd_en       <= 1'b0;
         addr_q      <= '0;
         fetch_valid <= 1'b0;
      end else begin
         running     <= 1'b1;
         hcnt        <= h_n;
         vcnt        <= v_n;
         hsync_out   <= ({1'b0, h_n} >= HS_BEGIN) && ({1'b0, h_n} < HS_END);
         vsync_out   <= !(({1'b0, v_n} >= VS_BEGIN) && ({1'b0, v_n} < VS_END));
         frame_start <= (h_n == 10'd0) && (v_n == 9'd0);
         rd_en       <= issue && !fetch_block;
         if (issue && !fetch_block)
            addr_q <= '{col: tgt_col[6:0], row: tgt_row[7:0]};
         if (slot)
            fetch_valid <= issue;
      end
   end

   assign rd_addr = addr_q;
   assign load    = running && (hcnt[2:0] == 3'd7);

`ifdef TRS80_TX_TEST_PATTERN_EN
   logic [7:0] pattern;

   // Capture the pattern byte for the target column/row in the fetch slot
   always_ff @(posedge dotclk or posedge reset) begin
      if (reset || !enable)
         pattern <= 8'h00;
      else if (slot)
         pattern <= pattern_byte(tgt_col[6:0], tgt_row[7:0],
                                 7'(H_ACTIVE / 8 - 1), 8'(V_ACTIVE - 1));
   end

   assign fetch_block = test_mode;
   assign load_data   = test_mode ? pattern : rd_data;
`else
   assign fetch_block = 1'b0;
   assign load_data   = rd_data;
`endif

   trs80_pixel_shifter u_shifter (
      .dotclk     (dotclk),
      .reset      (reset),
      .clear      (!enable),
      .load       (load),
      .load_valid (fetch_valid),
      .load_data  (load_data),
      .dot        (pixel_out)
   );

endmodule

// File: tb/tb_trs80_video_tx.sv
// tb_trs80_video_tx: directed self-checking bench for trs80_video_tx using a
// reduced raster (96x12 total, 64x8 active) so whole frames fit in a short run.
module tb_trs80_video_tx;

   localparam int HT = 96, HA = 64, HSS = 72, HSW = 8;
   localparam int VT = 12, VA = 8, VSS = 9, VSW = 2, LAT = 2;
   localparam int FRAME = HT * VT;

   logic        dotclk = 1'b0;
   logic        reset  = 1'b1;
   logic        enable = 1'b1;
   logic        rd_en;
   logic [14:0] rd_addr;
   logic [7:0]  rd_data = 8'h00;
   logic        hsync_out, vsync_out, pixel_out, frame_start;
`ifdef TRS80_TX_TEST_PATTERN_EN
   logic        test_mode = 1'b0;
`endif

   logic [7:0]  mem [0:32767];
   logic [7:0]  stage1 = 8'h00;
   int          tests = 0;
   int          fails = 0;

   always #5 dotclk = ~dotclk;

   trs80_video_tx #(
      .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW),
      .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_WIDTH(VSW),
      .RD_LATENCY(LAT)
   ) dut (
      .dotclk      (dotclk),
      .reset       (reset),
      .enable      (enable),
`ifdef TRS80_TX_TEST_PATTERN_EN
      .test_mode   (test_mode),
`endif
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .hsync_out   (hsync_out),
      .vsync_out   (vsync_out),
      .pixel_out   (pixel_out),
      .frame_start (frame_start)
   );

   // Two-cycle frame-buffer model; junk on cycles without a read
   always @(posedge dotclk) begin
      stage1  <= rd_en ? mem[rd_addr] : 8'hC3;
      rd_data <= stage1;
   end

   function automatic logic exp_dot(input int h, input int v);
      logic [7:0] b;
      if (h >= HA || v >= VA) return 1'b0;
      b = mem[((h / 8) << 8) | v];
      return b[7 - (h % 8)];
   endfunction

   task automatic wait_fs(input string name);
      int n;
      n = 0;
      do begin
         @(negedge dotclk);
         n++;
      end while (frame_start !== 1'b1 && n < 3000);
      if (frame_start !== 1'b1) begin
         tests++; fails++;
         $display("FAIL %s: frame_start not seen within 3000 cycles", name);
      end
   endtask

   task automatic test_reset;
      @(negedge dotclk);
      tests++;
      if ({hsync_out, vsync_out, pixel_out, rd_en, frame_start} !== 5'b01000 || rd_addr !== 15'h0) begin
         fails++;
         $display("FAIL reset_state: hs/vs/pix/rd_en/fs=%b rd_addr=%h, required 01000 addr 0000",
                  {hsync_out, vsync_out, pixel_out, rd_en, frame_start}, rd_addr);
      end
      reset = 1'b0;
      @(negedge dotclk);
      tests++;
      if (frame_start !== 1'b1) begin
         fails++; $display("FAIL reset_release_fs: frame_start=%b, required 1", frame_start);
      end
      repeat (75) @(negedge dotclk);
      tests++;
      if (hsync_out !== 1'b1) begin
         fails++; $display("FAIL hsync_h75: hsync_out=%b, required 1", hsync_out);
      end
      #2 reset = 1'b1;
      #1;
      tests++;
      if ({hsync_out, vsync_out, pixel_out, rd_en} !== 4'b0100) begin
         fails++;
         $display("FAIL async_reset: hs/vs/pix/rd_en=%b, required 0100",
                  {hsync_out, vsync_out, pixel_out, rd_en});
      end
      @(negedge dotclk) reset = 1'b0;
      @(negedge dotclk);
      tests++;
      if (frame_start !== 1'b1) begin
         fails++; $display("FAIL reset_rerelease_fs: frame_start=%b, required 1", frame_start);
      end
      $display("[TB] test_reset done");
   endtask

   task automatic test_sync;
      int hs_err, vs_err, hs_first, vs_fall0, vs_fall1, vs_rise;
      int h, v;
      logic prev_hs, prev_vs;
      hs_err = 0; vs_err = 0; hs_first = -1; vs_fall0 = -1; vs_fall1 = -1; vs_rise = -1;
      prev_hs = 1'b0; prev_vs = 1'b1;
      for (int k = 0; k < 2 * FRAME + 100; k++) begin
         h = k % HT;
         v = (k / HT) % VT;
         if (hsync_out !== (h >= HSS && h < HSS + HSW)) hs_err++;
         if (vsync_out !== !(v >= VSS && v < VSS + VSW)) vs_err++;
         if (hsync_out === 1'b1 && !prev_hs && hs_first < 0) hs_first = k;
         if (vsync_out === 1'b0 && prev_vs) begin
            if (vs_fall0 < 0) vs_fall0 = k; else if (vs_fall1 < 0) vs_fall1 = k;
         end
         if (vsync_out === 1'b1 && !prev_vs && vs_rise < 0) vs_rise = k;
         prev_hs = hsync_out; prev_vs = vsync_out;
         @(negedge dotclk);
      end
      tests++;
      if (hs_err != 0) begin fails++; $display("FAIL hsync_window: %0d wrong cycles, required 0", hs_err); end
      tests++;
      if (vs_err != 0) begin fails++; $display("FAIL vsync_window: %0d wrong cycles, required 0", vs_err); end
      tests++;
      if (hs_first != HSS) begin fails++; $display("FAIL hsync_first_rise: at %0d, required %0d", hs_first, HSS); end
      tests++;
      if (vs_fall0 != VSS * HT) begin fails++; $display("FAIL vsync_fall: at %0d, required %0d", vs_fall0, VSS * HT); end
      tests++;
      if (vs_fall1 - vs_fall0 != FRAME) begin
         fails++; $display("FAIL vsync_period: %0d, required %0d", vs_fall1 - vs_fall0, FRAME);
      end
      tests++;
      if (vs_rise - vs_fall0 != VSW * HT) begin
         fails++; $display("FAIL vsync_low: %0d, required %0d", vs_rise - vs_fall0, VSW * HT);
      end
      $display("[TB] test_sync done");
   endtask

   task automatic test_pixel;
      int err, h, v;
      logic [7:0] b53, b00;
      err = 0; b53 = 8'h00; b00 = 8'h00;
      wait_fs("pixel_sync");
      for (int k = 0; k < FRAME; k++) begin
         h = k % HT; v = k / HT;
         if (pixel_out !== exp_dot(h, v)) err++;
         if (v == 3 && h >= 40 && h < 48) b53 = {b53[6:0], pixel_out};
         if (v == 0 && h < 8) b00 = {b00[6:0], pixel_out};
         @(negedge dotclk);
      end
      tests++;
      if (b53 !== 8'hA5) begin fails++; $display("FAIL pixel_col5_row3: dots=%h, required a5", b53); end
      tests++;
      if (b00 !== 8'hFF) begin fails++; $display("FAIL pixel_col0_row0: dots=%h, required ff", b00); end
      tests++;
      if (err != 0) begin fails++; $display("FAIL pixel_frame: %0d wrong dots, required 0", err); end
      $display("[TB] test_pixel done");
   endtask

   task automatic test_fetch;
      int err, h, v, c, r, total, at_end;
      int cnt [0:VT-1];
      logic exp_en;
      err = 0; total = 0; at_end = 0;
      for (int i = 0; i < VT; i++) cnt[i] = 0;
      wait_fs("fetch_sync");
      for (int k = 0; k < FRAME; k++) begin
         h = k % HT; v = k / HT;
         c = h / 8 + 1; r = v;
         if (c == HT / 8) begin c = 0; r = (v + 1) % VT; end
         exp_en = (h % 8 == 7 - LAT) && c < HA / 8 && r < VA;
         if (rd_en !== exp_en) err++;
         if (rd_en === 1'b1) begin
            total++;
            cnt[rd_addr[7:0] % VT]++;
            if (rd_addr !== 15'((c << 8) | r)) err++;
         end
         if (v == VT - 1 && h == HT - 3) at_end = (rd_en === 1'b1 && rd_addr === 15'h0000) ? 1 : 0;
         @(negedge dotclk);
      end
      tests++;
      if (err != 0) begin fails++; $display("FAIL fetch_timing: %0d wrong cycles, required 0", err); end
      tests++;
      if (total != (HA / 8) * VA) begin fails++; $display("FAIL fetch_total: %0d, required %0d", total, (HA / 8) * VA); end
      tests++;
      if (cnt[0] != HA / 8 || cnt[VA - 1] != HA / 8 || cnt[VA] != 0) begin
         fails++; $display("FAIL fetch_per_row: row0=%0d row7=%0d row8=%0d, required 8 8 0", cnt[0], cnt[VA - 1], cnt[VA]);
      end
      tests++;
      if (at_end != 1) begin fails++; $display("FAIL fetch_row0_col0: not at last line hcnt %0d with addr 0", HT - 3); end
      $display("[TB] test_fetch done");
   endtask

   task automatic test_enable;
      int fs_cnt, c0_err, c1_err, h, v;
      fs_cnt = 0; c0_err = 0; c1_err = 0;
      wait_fs("enable_sync");
      repeat (3 * HT + 41) @(negedge dotclk);
      enable = 1'b0;
      @(negedge dotclk);
      tests++;
      if ({hsync_out, vsync_out, pixel_out, rd_en, frame_start} !== 5'b01000 || rd_addr !== 15'h0) begin
         fails++;
         $display("FAIL disable_idle: hs/vs/pix/rd_en/fs=%b rd_addr=%h, required 01000 addr 0000",
                  {hsync_out, vsync_out, pixel_out, rd_en, frame_start}, rd_addr);
      end
      repeat (4) @(negedge dotclk);
      enable = 1'b1;
      @(negedge dotclk);
      tests++;
      if (frame_start !== 1'b1) begin fails++; $display("FAIL reenable_fs: frame_start=%b, required 1", frame_start); end
      for (int k = 0; k < FRAME - 50; k++) begin
         h = k % HT; v = k / HT;
         if (frame_start === 1'b1) fs_cnt++;
         if (v == 0 && h < 8 && pixel_out !== 1'b0) c0_err++;
         if (v == 0 && h >= 8 && h < 16 && pixel_out !== exp_dot(h, v)) c1_err++;
         @(negedge dotclk);
      end
      tests++;
      if (fs_cnt != 1) begin fails++; $display("FAIL reenable_fs_count: %0d pulses, required 1", fs_cnt); end
      tests++;
      if (c0_err != 0) begin fails++; $display("FAIL reenable_col0_blank: %0d lit dots, required 0", c0_err); end
      tests++;
      if (c1_err != 0) begin fails++; $display("FAIL reenable_col1: %0d wrong dots, required 0", c1_err); end
      wait_fs("enable_sync2");
      repeat (VSS * HT + 75) @(negedge dotclk);
      tests++;
      if ({hsync_out, vsync_out} !== 2'b10) begin
         fails++; $display("FAIL sync_before_drop: hs/vs=%b, required 10", {hsync_out, vsync_out});
      end
      enable = 1'b0;
      @(negedge dotclk);
      tests++;
      if ({hsync_out, vsync_out} !== 2'b01) begin
         fails++; $display("FAIL sync_after_drop: hs/vs=%b, required 01", {hsync_out, vsync_out});
      end
      enable = 1'b1;
      @(negedge dotclk);
      tests++;
      if (frame_start !== 1'b1) begin fails++; $display("FAIL reenable2_fs: frame_start=%b, required 1", frame_start); end
      $display("[TB] test_enable done");
   endtask

`ifdef TRS80_TX_TEST_PATTERN_EN
   task automatic test_pattern;
      int rd_err, row0_err, h, v;
      logic [7:0] b11, b21;
      rd_err = 0; row0_err = 0; b11 = 8'h00; b21 = 8'h00;
      test_mode = 1'b1;
      wait_fs("pattern_sync");
      for (int k = 0; k < FRAME; k++) begin
         h = k % HT; v = k / HT;
         if (rd_en !== 1'b0) rd_err++;
         if (v == 0 && h < HA && pixel_out !== 1'b1) row0_err++;
         if (v == 1 && h >= 8 && h < 16) b11 = {b11[6:0], pixel_out};
         if (v == 1 && h >= 16 && h < 24) b21 = {b21[6:0], pixel_out};
         @(negedge dotclk);
      end
      test_mode = 1'b0;
      tests++;
      if (rd_err != 0) begin fails++; $display("FAIL pattern_rd_en: %0d strobes, required 0", rd_err); end
      tests++;
      if (row0_err != 0) begin fails++; $display("FAIL pattern_row0: %0d dark dots, required 0", row0_err); end
      tests++;
      if (b11 !== 8'h55) begin fails++; $display("FAIL pattern_col1_row1: %h, required 55", b11); end
      tests++;
      if (b21 !== 8'hAA) begin fails++; $display("FAIL pattern_col2_row1: %h, required aa", b21); end
      $display("[TB] test_pattern done");
   endtask
`endif

   initial begin
      for (int a = 0; a < 32768; a++) mem[a] = 8'h00;
      for (int c = 0; c < HA / 8; c++)
         for (int r = 0; r < VA; r++)
            mem[(c << 8) | r] = 8'((c * 37 + r * 11 + 1) & 255);
      mem[(5 << 8) | 3] = 8'hA5;
      mem[0]            = 8'hFF;
      test_reset();
      test_sync();
      test_pixel();
      test_fetch();
      test_enable();
`ifdef TRS80_TX_TEST_PATTERN_EN
      test_pattern();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
